inj_queue: RTL and testbench
============================

// Module: inj_queue
// PURPOSE
//  Injection FIFO directly upstream of the CALF injector stage. Buffers locally
//  generated flits from the node interface and presents the head flit on c_in;
//  the injector's `used` pulse pops it. Tracks head-of-line starvation
//  (consecutive cycles with a waiting flit and no free slot) for throttle logic.
// PARAMETERS
//  DEPTH         4    queue entries; power of two, >=2
//  STARVE_THRESH 8    starvation count at which `starve` asserts
//  STARVE_MAX    255  saturation value of the starvation counter (8-bit)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_flit    in   `steer_w flit from node interface; valid at [`valid_f]
//  in_ready   out  1        queue accepts in_flit this cycle
//  c_in       out  `steer_w head flit to injector; [`valid_f]=0 when empty
//  used       in   1        injector consumed c_in this cycle (pop)
//  count      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//  starve_cnt out  8        consecutive blocked cycles (saturating)
//  starve     out  1        starve_cnt >= STARVE_THRESH
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd/wr ptrs=0, count=0, starve_cnt=0; hence
//    in_ready=1, c_in=all-zero (valid=0), starve=0. Storage contents don't-care.
//  - push = in_flit[`valid_f] & in_ready; pop = used & c_in[`valid_f].
//  - in_ready = (count != DEPTH); registered-count only, no comb path from used.
//    Full and popping in same cycle: in_ready still 0 (no full-bypass).
//  - c_in = mem[rd_ptr] combinationally when count>0, valid bit as stored (1);
//    when count==0, c_in = 0. No empty bypass: flit pushed in cycle t first
//    appears on c_in in cycle t+1 (latency 1).
//  - Push and pop same cycle: both occur, count unchanged; ptrs wrap mod DEPTH.
//  - used while empty: ignored (no ptr/count change); flagged by assertion.
//  - in_flit with valid=0: never stored regardless of in_ready.
//  - starve_cnt next: 0 if count==0 or pop; else min(starve_cnt+1, STARVE_MAX).
//    starve is combinational from starve_cnt register.
//  - Stored flit bits are passed through unmodified (incl. steering fields).
//  - Mid-operation reset discards all queued flits; first cycle after release
//    behaves as empty.
// TESTING
//  1 Reset, push flit A (valid=1) cycle 1 -> c_in==A from cycle 2, count=1;
//    used in cycle 3 -> count=0, c_in valid=0 in cycle 4.
//  2 Push 4 flits A..D with used=0 -> count=4, in_ready=0; 5th flit E offered
//    not stored; pop 4x -> A,B,C,D in order, then empty.
//  3 Full, push+used same cycle -> push refused (in_ready=0), count 4->3; next
//    cycle push+used -> count stays 3; run 10 cycles -> ptr wrap, order intact.
//  4 One flit held, used=0 for 8 cycles -> starve_cnt=8, starve=1 at cycle 8;
//    used -> starve_cnt=0 next cycle; hold 300 cycles -> saturates at 255.
//  5 used=1 while empty, and in_flit valid=0 pushes -> count stays 0, no change.
//  6 Queue holding 3 flits, starve_cnt=5; assert rst_n=0 mid-cycle -> outputs
//    immediately count=0, in_ready=1, c_in valid=0, starve_cnt=0.

Source files
------------

// File: rtl/inj_queue.sv
// Injection FIFO in front of the CALF injector. Holds locally generated flits,
// shows the head flit on c_in, and pops it when the injector pulses `used`.
// Also counts consecutive cycles in which a flit waits without being taken
// (head-of-line starvation), for use by throttle logic.

`ifndef STEER_W
`define STEER_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif

module inj_queue #(
    parameter int DEPTH           = 4,
    parameter int STARVE_THRESH   = 8,
    parameter int STARVE_MAX      = 255,
    parameter bit CHECK_EMPTY_POP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [`STEER_W-1:0]     in_flit,
    output logic                    in_ready,
    output logic [`STEER_W-1:0]     c_in,
    input  logic                    used,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              starve_cnt,
    output logic                    starve
);

    localparam int              AW     = $clog2(DEPTH);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
    localparam logic [7:0]      THRESH = 8'(STARVE_THRESH);
    localparam logic [7:0]      SAT    = 8'(STARVE_MAX);

    logic [`STEER_W-1:0] mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic                empty;
    logic                push;
    logic                pop;

    // Readiness depends only on the registered count, so there is no
    // combinational path from `used` back to the node interface; a full queue
    // refuses a push even in the cycle it is being popped.
    assign empty    = (count == '0);
    assign in_ready = (count != FULL);
    assign c_in     = empty ? '0 : mem[rd_ptr];
    assign push     = in_flit[`VALID_F] & in_ready;
    assign pop      = used & c_in[`VALID_F];
    assign starve   = (starve_cnt >= THRESH);

    // Flit storage: written on push, flit bits kept verbatim.
    // NOTE: the storage array has no reset; its contents are unobservable
    // while count==0, and leaving it out keeps it a plain register file/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: clears when the queue is empty or the head is taken,
    // otherwise counts up and saturates at SAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SAT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Flags an injector that claims to consume a flit from an empty queue.
    always @(posedge clk) begin
        if (CHECK_EMPTY_POP && rst_n) begin
            assert (!(used && empty))
                else $error("inj_queue: used asserted while queue empty");
        end
    end

endmodule

// File: tb/tb_inj_queue.sv
// Directed bench for inj_queue: a vector table for the basic push/pop/empty
// behaviour plus hand-written sequences for wrap, starvation and reset.

`ifndef STEER_W
`define STEER_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif

module tb_inj_queue;

    logic                clk;
    logic                rst_n;
    logic [`STEER_W-1:0] in_flit;
    logic                in_ready;
    logic [`STEER_W-1:0] c_in;
    logic                used;
    logic [2:0]          count;
    logic [7:0]          starve_cnt;
    logic                starve;

    int n_cmp  = 0;
    int n_fail = 0;

    inj_queue #(
        .DEPTH           (4),
        .STARVE_THRESH   (8),
        .STARVE_MAX      (255),
        .CHECK_EMPTY_POP (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .c_in       (c_in),
        .used       (used),
        .count      (count),
        .starve_cnt (starve_cnt),
        .starve     (starve)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] flit;
        logic        used;
        logic [2:0]  cnt;
        logic        rdy;
        logic [15:0] cin;
        logic [7:0]  st;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    localparam logic [15:0] FA = 16'h8A01;
    localparam logic [15:0] FB = 16'h8B02;
    localparam logic [15:0] FC = 16'h8C03;
    localparam logic [15:0] FD = 16'hCD04;
    localparam logic [15:0] FE = 16'h8E05;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_cnt, input logic e_rdy,
                             input logic [15:0] e_cin, input logic [7:0] e_st);
        check({tag, ".count"},      32'(count),      32'(e_cnt));
        check({tag, ".in_ready"},   32'(in_ready),   32'(e_rdy));
        check({tag, ".c_in"},       32'(c_in),       32'(e_cin));
        check({tag, ".starve_cnt"}, 32'(starve_cnt), 32'(e_st));
        check({tag, ".starve"},     32'(starve),     32'(e_st >= 8'd8));
    endtask

    function automatic logic [15:0] mk(input int k);
        return {1'b1, 7'(k), 8'hA5 ^ 8'(k)};
    endfunction

    // Ends at a negedge with reset released and inputs idle.
    task automatic do_reset();
        in_flit = '0;
        used    = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] q [$];
    logic [15:0] f;

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        in_flit = '0;
        used    = 1'b0;

        // Reset state while rst_n is held low.
        #12;
        check_all("reset", 3'd0, 1'b1, 16'h0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Outputs in each row are the state before that row's clock edge.
        vt[0]  = '{FA,      1'b0, 3'd0, 1'b1, 16'h0, 8'd0};
        vt[1]  = '{16'h0,   1'b0, 3'd1, 1'b1, FA,    8'd0};
        vt[2]  = '{16'h0,   1'b1, 3'd1, 1'b1, FA,    8'd1};
        vt[3]  = '{16'h0,   1'b0, 3'd0, 1'b1, 16'h0, 8'd0};
        vt[4]  = '{FA,      1'b0, 3'd0, 1'b1, 16'h0, 8'd0};
        vt[5]  = '{FB,      1'b0, 3'd1, 1'b1, FA,    8'd0};
        vt[6]  = '{FC,      1'b0, 3'd2, 1'b1, FA,    8'd1};
        vt[7]  = '{FD,      1'b0, 3'd3, 1'b1, FA,    8'd2};
        vt[8]  = '{FE,      1'b0, 3'd4, 1'b0, FA,    8'd3};
        vt[9]  = '{16'h0,   1'b1, 3'd4, 1'b0, FA,    8'd4};
        vt[10] = '{16'h0,   1'b1, 3'd3, 1'b1, FB,    8'd0};
        vt[11] = '{16'h0,   1'b1, 3'd2, 1'b1, FC,    8'd0};
        vt[12] = '{16'h0,   1'b1, 3'd1, 1'b1, FD,    8'd0};
        vt[13] = '{16'h0123, 1'b1, 3'd0, 1'b1, 16'h0, 8'd0};
        vt[14] = '{16'h7FFF, 1'b1, 3'd0, 1'b1, 16'h0, 8'd0};
        vt[15] = '{16'h0,   1'b0, 3'd0, 1'b1, 16'h0, 8'd0};

        for (int i = 0; i < NV; i++) begin
            in_flit = vt[i].flit;
            used    = vt[i].used;
            #1;
            check_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].rdy, vt[i].cin, vt[i].st);
            @(negedge clk);
        end

        // Full queue: push+pop refuses the push, then steady push+pop wraps.
        do_reset();
        q.delete();
        for (int k = 0; k < 4; k++) begin
            in_flit = mk(k);
            q.push_back(mk(k));
            @(negedge clk);
        end
        in_flit = '0;
        #1;
        check("full.count", 32'(count), 32'd4);
        check("full.in_ready", 32'(in_ready), 32'd0);
        in_flit = mk(50);
        used    = 1'b1;
        #1;
        check("full_pop.c_in", 32'(c_in), 32'(q[0]));
        @(negedge clk);
        void'(q.pop_front());
        #1;
        check("after_full_pop.count", 32'(count), 32'd3);
        check("after_full_pop.in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 11; k++) begin
            f       = mk(10 + k);
            in_flit = f;
            used    = 1'b1;
            #1;
            check($sformatf("wrap%0d.c_in", k), 32'(c_in), 32'(q[0]));
            check($sformatf("wrap%0d.count", k), 32'(count), 32'd3);
            @(negedge clk);
            void'(q.pop_front());
            q.push_back(f);
        end
        in_flit = '0;
        for (int k = 0; k < 3; k++) begin
            used = 1'b1;
            #1;
            check($sformatf("drain%0d.c_in", k), 32'(c_in), 32'(q[0]));
            @(negedge clk);
            void'(q.pop_front());
        end
        used = 1'b0;
        #1;
        check("drained.count", 32'(count), 32'd0);
        check("drained.c_in", 32'(c_in), 32'd0);

        // Starvation: threshold crossing, clear on pop, saturation.
        do_reset();
        in_flit = FD;
        @(negedge clk);
        in_flit = '0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        #1;
        check("starve7.cnt", 32'(starve_cnt), 32'd7);
        check("starve7.flag", 32'(starve), 32'd0);
        @(negedge clk);
        #1;
        check("starve8.cnt", 32'(starve_cnt), 32'd8);
        check("starve8.flag", 32'(starve), 32'd1);
        used = 1'b1;
        @(negedge clk);
        used = 1'b0;
        #1;
        check("starve_clr.cnt", 32'(starve_cnt), 32'd0);
        check("starve_clr.flag", 32'(starve), 32'd0);
        in_flit = FC;
        @(negedge clk);
        in_flit = '0;
        for (int k = 0; k < 300; k++) @(negedge clk);
        #1;
        check("starve_sat.cnt", 32'(starve_cnt), 32'd255);
        check("starve_sat.flag", 32'(starve), 32'd1);
        check("starve_sat.c_in", 32'(c_in), 32'(FC));

        // Mid-operation asynchronous reset.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_flit = mk(k);
            @(negedge clk);
        end
        in_flit = '0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        #1;
        check("pre_rst.count", 32'(count), 32'd3);
        check("pre_rst.starve_cnt", 32'(starve_cnt), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 1'b1, 16'h0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("post_rst", 3'd0, 1'b1, 16'h0, 8'd0);
        in_flit = FB;
        @(negedge clk);
        in_flit = '0;
        #1;
        check_all("post_rst_push", 3'd1, 1'b1, FB, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
